alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
//
// PURPOSE
// Execute stage directly downstream of the register file. Consumes val_a/val_b
// (val_b is either a register or the 3-bit immediate, depending on mb_select).
// Computes an 8-bit result and flags, then issues a write-back (wb_load,
// wb_addr, result) to the register file's load/addr_a/d_in inputs.
// Single-cycle ops finish in 1 cycle. MUL is an iterative shift-add taking 8 cycles.
//
// PARAMETERS
// WIDTH     8   datapath width; MUL iterates WIDTH times
// ADDR_W    3   register address width (8 registers)
//
// PORTS
// clk        in   1       rising-edge clock
// reset      in   1       asynchronous, active-high; clears all state and outputs
// start      in   1       request; accepted only when busy=0
// op         in   3       opcode (see BEHAVIOUR)
// val_a      in   WIDTH   operand A (register file bus A)
// val_b      in   WIDTH   operand B (register file bus B)
// dest_addr  in   ADDR_W  write-back destination register
// busy       out  1       high whenever state != IDLE
// done       out  1       one-cycle completion pulse
// result     out  WIDTH   registered result; held until the next completion
// wb_load    out  1       write-back strobe; equals done
// wb_addr    out  ADDR_W  latched dest_addr, held with result
// flag_z     out  1       result == 0
// flag_n     out  1       result[WIDTH-1]
// flag_c     out  1       carry/borrow/overflow (per op)
//
// BEHAVIOUR
// - Reset: state=IDLE. busy, done, wb_load, result, wb_addr and all flags are 0.
//   Reset mid-operation aborts the op: no done, no wb_load.
// - FSM states: IDLE, MUL, DONE.
// - Accept: rising edge with state=IDLE and start=1. On that edge, latch
//   op, val_a, val_b and dest_addr.
//   - Non-MUL ops: go to DONE.
//   - MUL: go to MUL with count=0.
// - start while busy=1 (including in DONE) is ignored; latched operands are unchanged.
// - Latency: non-MUL ops assert done on the cycle after the accept edge.
//   MUL runs one shift-add per cycle. On the 8th MUL edge it enters DONE, so done
//   is asserted 8 cycles after accept.
// - DONE lasts one cycle: done=wb_load=busy=1, then returns to IDLE.
//   Maximum start rate: one per 2 cycles for non-MUL ops.
// - result, flags and wb_addr update only on the edge entering DONE.
// - Opcodes (A, B = latched operands; all arithmetic mod 2^8):
//   000 ADD  A+B;          C = carry out of bit 7
//   001 SUB  A-B;          C = borrow (A<B unsigned)
//   010 AND  A&B;          C = 0
//   011 OR   A|B;          C = 0
//   100 XOR  A^B;          C = 0
//   101 SHL  A<<B[2:0];    C = last bit shifted out (0 if shift amount is 0)
//   110 MUL  low byte of A*B, unsigned; C = (high byte != 0)
//   111 PASSB  B (load-immediate path); C = 0
// - MUL datapath: a 16-bit product accumulator and a shifting multiplier.
//   Results must equal the combinational A*B for all 65536 input pairs.
// - Z and N are always derived from the final 8-bit result.
//
// TESTING
// 1 ADD 200+100, dest=3 -> done and wb_load 1 cycle after accept; result=44,
//   C=1, Z=0, N=0, wb_addr=3.
// 2 SUB 5-5 -> result=0, Z=1, C=0.
//   SUB 3-5 -> result=254, C=1, N=1.
// 3 MUL 13*11 -> result=143, C=0, busy high for exactly 9 cycles.
//   MUL 16*16 -> result=0, C=1, Z=1.
// 4 start a MUL, then pulse start with new operands at cycles 2 and 9 (DONE) ->
//   both ignored; result is the first product; a single done pulse.
// 5 assert reset at MUL cycle 4 -> outputs 0 immediately; no wb_load.
//   After release, ADD 1+1 yields 2.
// 6 SHL 0x81 by 1 -> 0x02, C=1.
//   SHL by 0 -> A unchanged, C=0.
//   PASSB 0x05 -> 0x05, all flags 0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute stage: 1-cycle ALU ops, iterative 8-step MUL, registered write-back.
// Ports: clk/reset, start/op/val_a/val_b/dest_addr in; busy/done/result/wb_* /flags out.
module alu_exec_unit #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [WIDTH-1:0]  val_a,
  input  logic [WIDTH-1:0]  val_b,
  input  logic [ADDR_W-1:0] dest_addr,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wb_load,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_PSB = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic                z_q, z_d;
  logic                n_q, n_d;
  logic                c_q, c_d;

  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  shl;
  logic [WIDTH-1:0]    alu_r;
  logic                alu_c;
  logic [2*WIDTH-1:0]  step_acc;
  logic [WIDTH-1:0]    res_new;
  logic                c_new;
  logic                load_res;

  // Single-cycle ops evaluate straight off the input buses at accept.
  always_comb begin
    sum   = '0;
    shl   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    unique case (op)
      OP_ADD: begin
        sum   = {1'b0, val_a} + {1'b0, val_b};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_SUB: begin
        // bit WIDTH of the widened difference is the borrow
        sum   = {1'b0, val_a} - {1'b0, val_b};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_AND: alu_r = val_a & val_b;
      OP_OR:  alu_r = val_a | val_b;
      OP_XOR: alu_r = val_a ^ val_b;
      OP_SHL: begin
        // the last bit shifted out lands just above the result
        shl   = {{WIDTH{1'b0}}, val_a} << val_b[2:0];
        alu_r = shl[WIDTH-1:0];
        alu_c = shl[WIDTH];
      end
      OP_MUL: alu_r = '0;
      OP_PSB: alu_r = val_b;
    endcase
  end

  assign step_acc = mplier_q[0] ? acc_q + mcand_q : acc_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    dest_d    = dest_q;
    result_d  = result_q;
    wb_addr_d = wb_addr_q;
    z_d       = z_q;
    n_d       = n_q;
    c_d       = c_q;
    res_new   = '0;
    c_new     = 1'b0;
    load_res  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dest_d = dest_addr;
          if (op == OP_MUL) begin
            state_d  = ST_MUL;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, val_a};
            mplier_d = val_b;
          end else begin
            state_d   = ST_DONE;
            res_new   = alu_r;
            c_new     = alu_c;
            load_res  = 1'b1;
            wb_addr_d = dest_addr;
          end
        end
      end
      ST_MUL: begin
        acc_d    = step_acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d   = ST_DONE;
          res_new   = step_acc[WIDTH-1:0];
          c_new     = |step_acc[2*WIDTH-1:WIDTH];
          load_res  = 1'b1;
          wb_addr_d = dest_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load_res) begin
      result_d = res_new;
      z_d      = ~|res_new;
      n_d      = res_new[WIDTH-1];
      c_d      = c_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      wb_addr_q <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      c_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      dest_q    <= dest_d;
      result_q  <= result_d;
      wb_addr_q <= wb_addr_d;
      z_q       <= z_d;
      n_q       <= n_d;
      c_q       <= c_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign wb_load = done;
  assign result  = result_q;
  assign wb_addr = wb_addr_q;
  assign flag_z  = z_q;
  assign flag_n  = n_q;
  assign flag_c  = c_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed cases plus random traffic
// checked against an arithmetic reference model.
module tb_alu_exec_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = '0;
  logic [7:0] val_a = '0;
  logic [7:0] val_b = '0;
  logic [2:0] dest_addr = '0;
  logic       busy, done, wb_load, flag_z, flag_n, flag_c;
  logic [7:0] result;
  logic [2:0] wb_addr;

  alu_exec_unit #(.WIDTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .val_a(val_a), .val_b(val_b), .dest_addr(dest_addr),
    .busy(busy), .done(done), .result(result), .wb_load(wb_load),
    .wb_addr(wb_addr), .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] r;
    logic [2:0] addr;
    logic       z;
    logic       n;
    logic       c;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int o, input int a, input int b,
                                 input int d);
    exp_t e;
    int p, c, sh;
    p = 0;
    c = 0;
    case (o)
      0: begin p = a + b; c = (p > 255) ? 1 : 0; end
      1: begin p = a - b; c = (a < b) ? 1 : 0; end
      2: p = a & b;
      3: p = a | b;
      4: p = a ^ b;
      5: begin
        sh = b % 8;
        p  = a * (1 << sh);
        c  = (sh != 0) ? ((a >> (8 - sh)) & 1) : 0;
      end
      6: begin p = a * b; c = (p > 255) ? 1 : 0; end
      default: p = b;
    endcase
    e.r    = 8'(p & 255);
    e.addr = 3'(d);
    e.z    = ((p & 255) == 0);
    e.n    = ((p & 128) != 0);
    e.c    = (c != 0);
    return e;
  endfunction

  // Monitor: every completion must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (wb_load && !done) chk("wb_load_without_done", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("wb_load", int'(wb_load), 1);
          chk("result", int'(result), int'(e.r));
          chk("wb_addr", int'(wb_addr), int'(e.addr));
          chk("flag_z", int'(flag_z), int'(e.z));
          chk("flag_n", int'(flag_n), int'(e.n));
          chk("flag_c", int'(flag_c), int'(e.c));
        end
      end
    end
  end

  task automatic issue(input int o, input int a, input int b, input int d);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      chk("idle_timeout", 0, 1);
      return;
    end
    start     = 1'b1;
    op        = 3'(o);
    val_a     = 8'(a);
    val_b     = 8'(b);
    dest_addr = 3'(d);
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back(model(o, a, b, d));
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int cnt, done_at, ndone;

    // reset state
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wb_load", int'(wb_load), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_flags", int'({flag_z, flag_n, flag_c}), 0);
    chk("rst_wb_addr", int'(wb_addr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ADD with 1-cycle latency
    issue(0, 200, 100, 3);
    @(negedge clk);
    chk("add_latency_done", int'(done), 1);
    drain();

    issue(1, 5, 5, 1);
    issue(1, 3, 5, 2);
    drain();

    // MUL 13*11: busy 9 cycles, done 8 cycles after accept
    issue(6, 13, 11, 4);
    cnt = 0;
    done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done && done_at == 0) done_at = i;
      if (!busy) break;
      cnt++;
    end
    chk("mul_busy_cycles", cnt, 9);
    chk("mul_done_cycle", done_at, 9);
    drain();

    issue(6, 16, 16, 7);
    issue(6, 255, 255, 6);
    issue(6, 0, 200, 5);
    drain();

    // starts during MUL and during DONE are ignored
    issue(6, 7, 9, 5);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'd0; val_a = 8'd1; val_b = 8'd1; dest_addr = 3'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b1; op = 3'd7; val_a = 8'd2; val_b = 8'd3; dest_addr = 3'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_starts_no_extra_done", ndone, 0);
    drain();

    // reset mid-MUL aborts the operation
    issue(6, 200, 3, 6);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wb_load", int'(wb_load), 0);
    chk("abort_result", int'(result), 0);
    chk("abort_wb_addr", int'(wb_addr), 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wb_load) ndone++;
    end
    chk("abort_no_wb_load", ndone, 0);
    issue(0, 1, 1, 2);
    drain();

    // shifts and load-immediate
    issue(5, 8'h81, 1, 0);
    issue(5, 8'h5a, 0, 1);
    issue(5, 8'hff, 7, 2);
    issue(7, 0, 5, 3);
    issue(7, 9, 0, 4);
    drain();

    // random traffic
    for (int k = 0; k < 250; k++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
